// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and helpers for the TMR fault controller: controller states,
// replica identifiers and small replica-vector helpers.
package cv32e40p_tmr_pkg;

  // Controller states: normal voting, resync outstanding, unrecoverable.
  typedef enum logic [1:0] {
    TMR_IDLE  = 2'd0,
    TMR_REQ   = 2'd1,
    TMR_FATAL = 2'd2
  } tmr_state_e;

  // Replica identifier as reported by the voter.
  typedef logic [1:0] replica_id_t;

  // Voter code meaning "all three replicas disagree".
  localparam replica_id_t REPLICA_ALL = 2'd3;

  // Number of replicas being voted.
  localparam int unsigned NUM_REPLICAS = 3;

  // One-hot select of a replica; REPLICA_ALL maps to an empty mask.
  function automatic logic [NUM_REPLICAS-1:0] id_mask(input replica_id_t id);
    return 3'b001 << id;
  endfunction

  // Lowest-numbered set bit of a replica vector (0 when the vector is empty).
  function automatic replica_id_t lowest_set(input logic [NUM_REPLICAS-1:0] vec);
    replica_id_t id;
    id = 2'd0;
    for (int k = NUM_REPLICAS - 1; k >= 0; k--) begin
      if (vec[k]) begin
        id = replica_id_t'(k);
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_err_cnt.sv
// Per-replica error counter: clear has priority, increments saturate at the
// all-ones value and decrements stop at zero so decay can never underflow.
module cv32e40p_tmr_err_cnt
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear, then saturating increment, then floored decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (dec_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// TMR fault controller: counts voter disagreements per replica, requests a
// resync (stalling the core) once a replica crosses the threshold, decays
// counts during long fault-free stretches and escalates to a sticky FATAL
// state on all-disagree, a second bad replica, or a missing resync ack.
module cv32e40p_tmr_fault_ctrl
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned ERR_THRESH   = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned DECAY_PERIOD = 1024,
  parameter int unsigned ACK_TIMEOUT  = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fault_i,
  input  logic [1:0]                fault_id_i,
  input  logic                      clear_i,
  output logic                      resync_req_o,
  output logic [1:0]                resync_id_o,
  input  logic                      resync_ack_i,
  output logic                      stall_o,
  output logic                      fatal_o,
  output logic [3*CNT_W-1:0]        err_cnt_o
);

  // A threshold of zero would request resync forever; one above the counter
  // range could never be reached.
  if ((ERR_THRESH == 0) || (ERR_THRESH > (2 ** CNT_W) - 1)) begin : g_thresh_chk
    $error("ERR_THRESH must lie in 1..2^CNT_W-1");
  end

  localparam int unsigned DECAY_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   THRESH_C   = CNT_W'(ERR_THRESH);

  tmr_state_e                              state_d;
  tmr_state_e                              state_q;
  replica_id_t                             id_d;
  replica_id_t                             id_q;
  logic [TO_W-1:0]                         to_d;
  logic [TO_W-1:0]                         to_q;
  logic [DECAY_W-1:0]                      decay_d;
  logic [DECAY_W-1:0]                      decay_q;

  logic [NUM_REPLICAS-1:0][CNT_W-1:0]      cnt_s;
  logic [NUM_REPLICAS-1:0]                 over_s;
  logic [NUM_REPLICAS-1:0]                 fault_mask_s;
  logic [NUM_REPLICAS-1:0]                 other_mask_s;
  logic [NUM_REPLICAS-1:0]                 inc_s;
  logic [NUM_REPLICAS-1:0]                 dec_s;
  logic [NUM_REPLICAS-1:0]                 clr_s;
  logic                                    fault_all_s;

  // One saturating counter per replica; over_s flags replicas at threshold.
  for (genvar g = 0; g < NUM_REPLICAS; g++) begin : g_cnt
    cv32e40p_tmr_err_cnt #(
      .CNT_W (CNT_W)
    ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr_s[g]),
      .inc_i (inc_s[g]),
      .dec_i (dec_s[g]),
      .cnt_o (cnt_s[g])
    );
    assign over_s[g] = (cnt_s[g] >= THRESH_C);
  end

  assign fault_all_s  = fault_i && (fault_id_i == REPLICA_ALL);
  assign fault_mask_s = fault_i ? id_mask(fault_id_i) : 3'b000;
  // Replicas other than the one currently being resynced.
  assign other_mask_s = ~id_mask(id_q);

  // Controller next state, counter commands, decay and ack-timeout timers.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    to_d    = to_q;
    decay_d = decay_q;
    inc_s   = 3'b000;
    dec_s   = 3'b000;
    clr_s   = 3'b000;
    if (clear_i) begin
      state_d = TMR_IDLE;
      id_d    = 2'd0;
      to_d    = '0;
      decay_d = '0;
      clr_s   = 3'b111;
    end else if (fault_all_s) begin
      state_d = TMR_FATAL;
      to_d    = '0;
      decay_d = '0;
    end else begin
      case (state_q)
        TMR_IDLE: begin
          inc_s = fault_mask_s;
          to_d  = '0;
          // A fault restarts the quiet window, so it can never meet a tick.
          if (fault_i) begin
            decay_d = '0;
          end else if (decay_q == DECAY_LAST) begin
            decay_d = '0;
            dec_s   = 3'b111;
          end else begin
            decay_d = decay_q + DECAY_W'(1);
          end
          if (|over_s) begin
            state_d = TMR_REQ;
            id_d    = lowest_set(over_s);
          end else begin
            state_d = TMR_IDLE;
          end
        end
        TMR_REQ: begin
          // The replica under resync is known bad; its faults carry no news.
          inc_s   = fault_mask_s & other_mask_s;
          decay_d = '0;
          if (|(over_s & other_mask_s)) begin
            state_d = TMR_FATAL;
            to_d    = '0;
          end else if (resync_ack_i) begin
            state_d = TMR_IDLE;
            to_d    = '0;
            clr_s   = id_mask(id_q);
          end else if (to_q == TO_LAST) begin
            state_d = TMR_FATAL;
            to_d    = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        TMR_FATAL: begin
          to_d    = '0;
          decay_d = '0;
        end
        default: begin
          state_d = TMR_FATAL;
          to_d    = '0;
          decay_d = '0;
        end
      endcase
    end
  end

  // Controller state and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TMR_IDLE;
      id_q    <= 2'd0;
      to_q    <= '0;
      decay_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      to_q    <= to_d;
      decay_q <= decay_d;
    end
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  assign resync_req_o = (state_q == TMR_REQ);
  assign resync_id_o  = (state_q == TMR_REQ) ? id_q : 2'd0;
  assign stall_o      = (state_q == TMR_REQ) || (state_q == TMR_FATAL);
  assign fatal_o      = (state_q == TMR_FATAL);
  assign err_cnt_o    = cnt_s;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_ctrl.sv
// Self-checking bench for cv32e40p_tmr_fault_ctrl: directed scenarios with
// literal expectations plus a randomized run, all compared every cycle
// against a behavioural model of the controller's rules.
module tb_cv32e40p_tmr_fault_ctrl;

  localparam int THR  = 4;
  localparam int CW   = 4;
  localparam int DP   = 1024;
  localparam int TO   = 256;
  localparam int CMAX = 15;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        fault_i      = 1'b0;
  logic [1:0]  fault_id_i   = 2'd0;
  logic        clear_i      = 1'b0;
  logic        resync_ack_i = 1'b0;
  logic        resync_req_o;
  logic [1:0]  resync_id_o;
  logic        stall_o;
  logic        fatal_o;
  logic [11:0] err_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Model: per-replica counts, mode (0 normal, 1 awaiting ack, 2 fatal),
  // replica being resynced, cycles spent awaiting ack, quiet normal cycles.
  int m_cnt[3];
  int m_mode;
  int m_id;
  int m_age;
  int m_quiet;

  cv32e40p_tmr_fault_ctrl #(
    .ERR_THRESH   (THR),
    .CNT_W        (CW),
    .DECAY_PERIOD (DP),
    .ACK_TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fault_i      (fault_i),
    .fault_id_i   (fault_id_i),
    .clear_i      (clear_i),
    .resync_req_o (resync_req_o),
    .resync_id_o  (resync_id_o),
    .resync_ack_i (resync_ack_i),
    .stall_o      (stall_o),
    .fatal_o      (fatal_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_mode  = 0;
    m_id    = 0;
    m_age   = 0;
    m_quiet = 0;
  endtask

  // Apply the controller's rules for one clock edge with the given inputs.
  task automatic model_edge(input logic f, input logic [1:0] fid, input logic clr, input logic ack);
    int n[3];
    int first;
    bit tick;
    bit other;
    for (int k = 0; k < 3; k++) n[k] = m_cnt[k];
    if (clr) begin
      for (int k = 0; k < 3; k++) n[k] = 0;
      m_mode = 0; m_id = 0; m_age = 0; m_quiet = 0;
    end else if (f && fid == 2'd3) begin
      m_mode = 2; m_quiet = 0;
    end else if (m_mode == 0) begin
      first = -1;
      for (int k = 2; k >= 0; k--) if (m_cnt[k] >= THR) first = k;
      tick = !f && (m_quiet == DP - 1);
      m_quiet = (f || tick) ? 0 : m_quiet + 1;
      for (int k = 0; k < 3; k++) begin
        if (f && fid == k && n[k] < CMAX) n[k]++;
        if (tick && n[k] > 0) n[k]--;
      end
      if (first >= 0) begin
        m_mode = 1; m_id = first; m_age = 0;
      end
    end else if (m_mode == 1) begin
      m_quiet = 0;
      other = 0;
      for (int k = 0; k < 3; k++) begin
        if (k != m_id && m_cnt[k] >= THR) other = 1;
        if (k != m_id && f && fid == k && n[k] < CMAX) n[k]++;
      end
      if (other) m_mode = 2;
      else if (ack) begin n[m_id] = 0; m_mode = 0; end
      else if (m_age == TO - 1) m_mode = 2;
      else m_age++;
    end
    for (int k = 0; k < 3; k++) m_cnt[k] = n[k];
  endtask

  task automatic check_model(input string tag);
    logic [16:0] got;
    logic [16:0] exp;
    got = {fatal_o, stall_o, resync_req_o, resync_id_o, err_cnt_o};
    exp = {(m_mode == 2), (m_mode != 0), (m_mode == 1),
           (m_mode == 1) ? 2'(m_id) : 2'd0,
           4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %05h expected %05h (fatal,stall,req,id,cnt2,cnt1,cnt0)",
               tag, $time, got, exp);
    end
  endtask

  task automatic check_lit(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic f, input logic [1:0] fid, input logic clr, input logic ack,
                     input string tag);
    fault_i      = f;
    fault_id_i   = fid;
    clear_i      = clr;
    resync_ack_i = ack;
    @(posedge clk);
    model_edge(f, fid, clr, ack);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string tag);
    #3 rst_n = 1'b0;
    #1;
    check_lit({tag, "_outs"}, {fatal_o, stall_o, resync_req_o, resync_id_o, err_cnt_o}, 32'd0);
    model_reset();
    check_model(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check_lit("reset_outs", {fatal_o, stall_o, resync_req_o, resync_id_o, err_cnt_o}, 32'd0);
    check_model("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Threshold then ack on replica 1.
    repeat (4) cyc(1'b1, 2'd1, 1'b0, 1'b0, "thr_fault");
    check_lit("thr_cnt1", err_cnt_o[7:4], 32'd4);
    check_lit("thr_noreq_yet", resync_req_o, 32'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "thr_enter");
    check_lit("thr_req_id_stall", {resync_req_o, resync_id_o, stall_o}, 32'b1011);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, "thr_ack");
    check_lit("ack_cnt1", err_cnt_o[7:4], 32'd0);
    check_lit("ack_idle", {resync_req_o, stall_o, fatal_o}, 32'd0);

    // Decay of replica 0 with no underflow.
    repeat (3) cyc(1'b1, 2'd0, 1'b0, 1'b0, "decay_fault");
    check_lit("decay_cnt0_start", err_cnt_o[3:0], 32'd3);
    repeat (1023) cyc(1'b0, 2'd0, 1'b0, 1'b0, "decay_wait");
    check_lit("decay_before_tick", err_cnt_o[3:0], 32'd3);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "decay_tick1");
    check_lit("decay_after_1024", err_cnt_o[3:0], 32'd2);
    repeat (2048) cyc(1'b0, 2'd0, 1'b0, 1'b0, "decay_wait2");
    check_lit("decay_after_3072", err_cnt_o[3:0], 32'd0);
    repeat (1030) cyc(1'b0, 2'd0, 1'b0, 1'b0, "decay_floor");
    check_lit("decay_no_underflow", err_cnt_o, 32'd0);

    // Second replica crossing threshold while replica 2 is being resynced.
    repeat (4) cyc(1'b1, 2'd2, 1'b0, 1'b0, "sec_fault2");
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "sec_enter");
    check_lit("sec_req_id2", {resync_req_o, resync_id_o}, 32'b110);
    cyc(1'b1, 2'd2, 1'b0, 1'b0, "sec_ignored");
    check_lit("sec_cnt2_held", err_cnt_o[11:8], 32'd4);
    repeat (4) cyc(1'b1, 2'd0, 1'b0, 1'b0, "sec_fault0");
    check_lit("sec_not_yet", {fatal_o, resync_req_o}, 32'b01);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "sec_fatal");
    check_lit("sec_fatal_outs", {fatal_o, stall_o, resync_req_o}, 32'b110);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, "sec_clear");
    check_lit("clear_outs", {fatal_o, stall_o, resync_req_o, resync_id_o, err_cnt_o}, 32'd0);

    // Ack timeout: fatal after exactly TO cycles in REQ.
    repeat (4) cyc(1'b1, 2'd0, 1'b0, 1'b0, "to_fault");
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "to_enter");
    repeat (TO - 1) cyc(1'b0, 2'd0, 1'b0, 1'b0, "to_wait");
    check_lit("to_last_cycle", {fatal_o, resync_req_o}, 32'b01);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "to_expire");
    check_lit("to_fatal", {fatal_o, resync_req_o}, 32'b10);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, "to_clear");
    repeat (4) cyc(1'b1, 2'd0, 1'b0, 1'b0, "to2_fault");
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "to2_enter");
    repeat (TO - 1) cyc(1'b0, 2'd0, 1'b0, 1'b0, "to2_wait");
    cyc(1'b0, 2'd0, 1'b0, 1'b1, "to2_late_ack");
    check_lit("to_ack_wins", {fatal_o, stall_o, resync_req_o, err_cnt_o[3:0]}, 32'd0);

    // All-disagree, then resets in FATAL and mid-REQ.
    cyc(1'b1, 2'd3, 1'b0, 1'b0, "all_fault");
    check_lit("all_fatal", fatal_o, 32'd1);
    reset_pulse("rst_fatal");
    repeat (4) cyc(1'b1, 2'd1, 1'b0, 1'b0, "rst_fault");
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "rst_enter");
    check_lit("rst_in_req", resync_req_o, 32'd1);
    reset_pulse("rst_req");

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      logic       f;
      logic [1:0] fid;
      logic       clr;
      logic       ack;
      f   = ($urandom_range(0, 99) < 15);
      fid = ($urandom_range(0, 99) < 2) ? 2'd3 : 2'($urandom_range(0, 2));
      clr = ($urandom_range(0, 999) < 5);
      ack = ($urandom_range(0, 99) < 8);
      cyc(f, fid, clr, ack, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
